// File: rtl/lsu_ram_ctrl.sv
// Load/store unit front-end for a single-port synchronous-read RAM.
// It accepts one RV32I load or store at a time and rejects bad sizes,
// misaligned accesses and out-of-range addresses without touching the RAM.
// Sub-word stores are done as read-modify-write because the RAM has no
// byte enables.
module lsu_ram_ctrl #(
  parameter int ANCHO = 32,
  parameter int LARGO = 1024,
  localparam int AW = $clog2(LARGO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [ANCHO-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [ANCHO-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [ANCHO-1:0] ram_din,
  input  logic [ANCHO-1:0] ram_dout
);

  localparam int LANES = ANCHO / 8;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t           state_reg, state_next;
  logic             accept;
  logic             req_err;
  logic             size_err, align_err, range_err;

  // Request fields captured at acceptance
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [AW+1:0]    addr_reg;
  logic [15:0]      wdata_reg;

  logic [ANCHO-1:0] din_reg;
  logic [ANCHO-1:0] rsp_rdata_reg;
  logic             rsp_err_reg;

  logic [ANCHO-1:0] merged;
  logic [ANCHO-1:0] load_val;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign accept = req_valid && (state_reg == IDLE);

  // Classify the incoming request: bad size code, misalignment or address beyond the RAM
  always_comb begin
    size_err  = 1'b0;
    align_err = 1'b0;
    range_err = ((req_addr >> (AW + 2)) != 32'd0);
    if (req_we) begin
      size_err = (req_funct3 > 3'd2);
    end else begin
      size_err = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    case (req_funct3[1:0])
      2'd1:    align_err = req_addr[0];
      2'd2:    align_err = (req_addr[1:0] != 2'd0);
      default: align_err = 1'b0;
    endcase
    req_err = size_err | align_err | range_err;
  end

  // Store merge: replace only the addressed byte (SB) or halfword (SH) lanes
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic       hit;
    logic [7:0] src;
    assign hit = (funct3_reg[1:0] == 2'd0) ? (addr_reg[1:0] == 2'(gi))
                                           : (addr_reg[1] == 1'(gi / 2));
    assign src = (funct3_reg[1:0] == 2'd0) ? wdata_reg[7:0]
                                           : wdata_reg[8*(gi%2) +: 8];
    assign merged[8*gi +: 8] = hit ? src : ram_dout[8*gi +: 8];
  end

  // Load extraction: pick the addressed byte/halfword and extend it
  always_comb begin
    byte_sel = ram_dout[{addr_reg[1:0], 3'b000} +: 8];
    half_sel = ram_dout[{addr_reg[1], 4'b0000} +: 16];
    case (funct3_reg)
      3'd0:    load_val = {{(ANCHO-8){byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{(ANCHO-16){half_sel[15]}}, half_sel};
      3'd2:    load_val = ram_dout;
      3'd4:    load_val = {{(ANCHO-8){1'b0}}, byte_sel};
      3'd5:    load_val = {{(ANCHO-16){1'b0}}, half_sel};
      default: load_val = '0;
    endcase
  end

  // Next-state logic; full-word stores skip the read phase
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_we && (req_funct3 == 3'd2)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: capture request, build write data, latch the response on entry to RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      din_reg       <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr[AW+1:0];
        wdata_reg  <= req_wdata[15:0];
        din_reg    <= req_wdata;
      end
      if ((state_reg == CAP) && we_reg) begin
        din_reg <= merged;
      end
      if ((state_next == RESP) && (state_reg != RESP)) begin
        // Only rejected requests jump straight from IDLE to RESP
        rsp_err_reg   <= (state_reg == IDLE);
        rsp_rdata_reg <= ((state_reg == CAP) && !we_reg) ? load_val : '0;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign ram_we    = (state_reg == WR);
  assign ram_addr  = addr_reg[AW+1:2];
  assign ram_din   = din_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
